// File: rtl/store_merge_unit.sv
// Store path of the data-memory stage: sw/sh/sb with alignment checking against a
// word-only memory, sub-word stores done as read-modify-write.
module store_merge_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        store_option,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReject = 3'd1;
    localparam logic [2:0] StRead   = 3'd2;
    localparam logic [2:0] StMerge  = 3'd3;
    localparam logic [2:0] StWrite  = 3'd4;

    localparam logic [1:0] OptSw = 2'b00;
    localparam logic [1:0] OptSb = 2'b01;
    localparam logic [1:0] OptSh = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [1:0]        opt_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [31:0]       data_q;
    logic [31:0]       merged;
    logic              reject;

    always_comb begin
        reject = 1'b0;
        unique case (store_option)
            OptSw:   reject = (addr[1:0] != 2'b00);
            OptSb:   reject = 1'b0;
            OptSh:   reject = addr[0];
            default: reject = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (reject)               state_d = StReject;
                    else if (store_option == OptSw) state_d = StWrite;
                    else                      state_d = StRead;
                end
            end
            StReject: state_d = StIdle;
            StRead:   state_d = StMerge;
            StMerge:  state_d = StWrite;
            StWrite:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // New byte/half replaces its little-endian lane; other lanes come from memory.
    always_comb begin
        merged = mem_rdata;
        if (opt_q == OptSb) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            opt_q   <= 2'b00;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                opt_q   <= store_option;
                lane_q  <= addr[1:0];
                waddr_q <= addr[ADDR_W-1:2];
                data_q  <= wdata;
            end else if (state_q == StMerge) begin
                data_q <= merged;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StReject) || (state_q == StWrite);
    assign misalign  = (state_q == StReject);
    assign mem_rd_en = (state_q == StRead);
    assign mem_wr_en = (state_q == StWrite);
    assign mem_addr  = waddr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed stores, rejects, reset abort
// and busy handling, with expected writes queued at request time.
module tb_store_merge_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  store_option;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;

    logic [31:0] rdata_val;
    int          total;
    int          bad;

    typedef struct {
        logic        mis;
        logic        sub;
        logic [29:0] waddr;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .store_option (store_option),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .misalign     (misalign),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata)
    );

    always #5 clk = ~clk;

    // Memory returns data only in the cycle after a read strobe, X otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? rdata_val : 32'hxxxx_xxxx;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b want=0", misalign); end
        total++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            bad++; $display("FAIL reset_strobes got=%b%b want=00", mem_rd_en, mem_wr_en);
        end
        total++; if (mem_addr !== 30'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drive one request at the current negedge and check it against the scoreboard.
    task automatic run_req(input string name, input logic [1:0] opt, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input logic exp_mis,
                           input logic [31:0] exp_data, input int exp_lat, input bit hold);
        exp_t        e;
        int          cyc;
        int          rd_n;
        int          wr_n;
        int          rd_cyc;
        logic [29:0] rd_a;
        bit          got;
        bit          both;
        e.mis   = exp_mis;
        e.sub   = !exp_mis && (opt != 2'b00);
        e.waddr = a[31:2];
        e.data  = exp_data;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        rdata_val = rd;
        rd_n = 0; wr_n = 0; rd_cyc = -1; rd_a = '0; got = 0; both = 0;
        start = 1'b1; store_option = opt; addr = a; wdata = wd;
        @(negedge clk);
        cyc = 1;
        while (!got && cyc <= 8) begin
            if (!hold) start = 1'b0;
            store_option = 2'($urandom_range(3));
            addr = $urandom;
            wdata = $urandom;
            if (mem_rd_en === 1'b1) begin rd_n++; rd_cyc = cyc; rd_a = mem_addr; end
            if (mem_wr_en === 1'b1) wr_n++;
            if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) both = 1;
            if (done === 1'b1) got = 1;
            else begin @(negedge clk); cyc++; end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        total++; if (!got) begin bad++; $display("FAIL %s_timeout no done within 8 cycles", name); end
        if (got) begin
            total++; if (cyc != e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, e.lat); end
            total++; if (misalign !== e.mis) begin
                bad++; $display("FAIL %s_misalign got=%b want=%b", name, misalign, e.mis);
            end
            total++; if (mem_wr_en !== !e.mis) begin
                bad++; $display("FAIL %s_wr_en got=%b want=%b", name, mem_wr_en, !e.mis);
            end
            if (!e.mis) begin
                total++; if (mem_addr !== e.waddr) begin
                    bad++; $display("FAIL %s_addr got=%h want=%h", name, mem_addr, e.waddr);
                end
                total++; if (mem_wdata !== e.data) begin
                    bad++; $display("FAIL %s_wdata got=%h want=%h", name, mem_wdata, e.data);
                end
            end
        end
        total++; if (rd_n != (e.sub ? 1 : 0)) begin
            bad++; $display("FAIL %s_rd_count got=%0d want=%0d", name, rd_n, e.sub ? 1 : 0);
        end
        if (e.sub) begin
            total++; if (rd_cyc != 1 || rd_a !== e.waddr) begin
                bad++; $display("FAIL %s_read got=cyc%0d/%h want=cyc1/%h", name, rd_cyc, rd_a, e.waddr);
            end
        end
        total++; if (wr_n != (e.mis ? 0 : 1) || both) begin
            bad++; $display("FAIL %s_wr_count got=%0d both=%0d want=%0d", name, wr_n, both, e.mis ? 0 : 1);
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            bad++; $display("FAIL %s_idle got=done%b busy%b wr%b want=000", name, done, busy, mem_wr_en);
        end
        if (!e.mis) begin
            total++; if (mem_wdata !== e.data || mem_addr !== e.waddr) begin
                bad++; $display("FAIL %s_hold got=%h/%h want=%h/%h", name, mem_addr, mem_wdata,
                                e.waddr, e.data);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int wr_n;
        int done_n;
        int busy_n;
        wr_n = 0; done_n = 0; busy_n = 0;
        rdata_val = 32'h5566_7788;
        start = 1'b1; store_option = 2'b01; addr = 32'h0000_0020; wdata = 32'h0000_0077;
        @(negedge clk);
        start = 1'b0;
        if (mem_wr_en === 1'b1) wr_n++;
        @(negedge clk);
        if (mem_wr_en === 1'b1) wr_n++;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (mem_wdata !== 32'h0 || mem_addr !== 30'h0) begin
            bad++; $display("FAIL rstmid_clear got=%h/%h want=0/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            if (mem_wr_en === 1'b1) wr_n++;
            if (done === 1'b1) done_n++;
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
        total++; if (wr_n != 0) begin bad++; $display("FAIL rstmid_write got=%0d want=0", wr_n); end
        total++; if (done_n != 0 || busy_n != 0) begin
            bad++; $display("FAIL rstmid_after got=done%0d busy%0d want=0/0", done_n, busy_n);
        end
    endtask

    task automatic test_sw();
        run_req("sw", 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0);
    endtask

    task automatic test_sb();
        run_req("sb_l2", 2'b01, 32'h0000_0022, 32'h0000_00A5, 32'h1122_3344, 1'b0, 32'h11A5_3344, 3, 0);
        run_req("sb_l0", 2'b01, 32'h0000_0100, 32'hFFFF_FF5C, 32'h1122_3344, 1'b0, 32'h1122_335C, 3, 0);
        run_req("sb_l3", 2'b01, 32'h0000_0107, 32'h0000_00E1, 32'h1122_3344, 1'b0, 32'hE122_3344, 3, 0);
    endtask

    task automatic test_sh();
        run_req("sh_hi", 2'b11, 32'h0000_0006, 32'hFFFF_BEEF, 32'h1122_3344, 1'b0, 32'hBEEF_3344, 3, 0);
        run_req("sh_lo", 2'b11, 32'h0000_0004, 32'hFFFF_BEEF, 32'h1122_3344, 1'b0, 32'h1122_BEEF, 3, 0);
    endtask

    task automatic test_misalign();
        run_req("mis_sw", 2'b00, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1, 32'h0, 1, 0);
        run_req("mis_sh", 2'b11, 32'h0000_0005, 32'h1234_5678, 32'h0, 1'b1, 32'h0, 1, 0);
        run_req("mis_rsv", 2'b10, 32'h0000_0008, 32'h1234_5678, 32'h0, 1'b1, 32'h0, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_req("busy_sb", 2'b01, 32'h0000_0021, 32'h0000_005A, 32'h1122_3344, 1'b0, 32'h1122_5A44, 3, 1);
        run_req("b2b_sw", 2'b00, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, 1'b0, 32'hCAFE_F00D, 1, 0);
        run_req("b2b_sh", 2'b11, 32'h0000_0032, 32'h0000_1234, 32'hA0B0_C0D0, 1'b0, 32'h1234_C0D0, 3, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; store_option = 2'b00;
        addr = 32'h0; wdata = 32'h0; rdata_val = 32'h0;
        total = 0; bad = 0;
        test_reset();
        test_reset_mid_op();
        test_sw();
        test_sb();
        test_sh();
        test_misalign();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Write-side counterpart of the load-extraction path in the data-memory stage of the multi-cycle MIPS CPU.
- Takes a store request (sw, sh, sb), checks its alignment and drives a word-only data memory.
- Full-word stores are written directly.
- Sub-word stores use a read-modify-write sequence: read the word, merge the new byte/half into the correct lane, write the word back.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request strobe; sampled only in IDLE.
- store_option  input  2  2'b00 sw, 2'b01 sb, 2'b11 sh, 2'b10 reserved.
- addr  input  ADDR_W  byte address of the store.
- wdata  input  32  register data; sb uses [7:0], sh uses [15:0].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the request completes (written or rejected).
- misalign  output  1  one-cycle pulse together with done when the request is rejected.
- mem_addr  output  ADDR_W-2  word address to the data memory.
- mem_rd_en  output  1  read strobe; data memory returns mem_rdata on the next cycle.
- mem_rdata  input  32  read data, valid the cycle after mem_rd_en.
- mem_wr_en  output  1  word write strobe.
- mem_wdata  output  32  word to write.

Behaviour:
- Reset: state=IDLE; busy, done, misalign, mem_rd_en and mem_wr_en are 0; mem_addr and mem_wdata are 0. The internal request registers are cleared.
- Reset asserted mid-operation aborts the request: no write strobe is issued, and no done pulse is issued after reset releases.
- Request capture: on start in IDLE, addr, wdata and store_option are registered. The inputs may change afterwards without effect.
- start while busy is ignored; it is neither queued nor flagged.
- Byte order is little-endian: byte lane k = bits [8k+7:8k], selected by addr[1:0]; half lane = addr[1].
- Misalignment rules:
  - sw with addr[1:0]!=0 is rejected.
  - sh with addr[0]=1 is rejected.
  - Reserved option 2'b10 is rejected.
- State machine:
  - IDLE: start + rejected -> REJECT. start + sw -> WRITE. start + sb/sh -> READ.
  - REJECT (1 cycle): done=1, misalign=1, no memory strobes -> IDLE.
  - READ (1 cycle): mem_rd_en=1, mem_addr=addr[ADDR_W-1:2] -> MERGE.
  - MERGE (1 cycle): captures mem_rdata. The new byte/half replaces its lane; all other lanes are kept from mem_rdata. The merged word is registered -> WRITE.
  - WRITE (1 cycle): mem_wr_en=1, mem_addr held, mem_wdata = merged word (sb/sh) or the captured wdata (sw); done=1 -> IDLE.
- Latency, counted from the start cycle (edge 0):
  - sw: write and done one cycle later.
  - sb/sh: read at +1, write and done at +3.
  - rejected request: done and misalign at +1.
- Back-to-back: a new start is accepted in the IDLE cycle that follows done. Maximum throughput is one sw per 2 cycles or one sub-word store per 4 cycles.
- mem_rd_en and mem_wr_en are never high in the same cycle. Each is high for exactly one cycle per request.
- mem_wdata and mem_addr hold their last values while IDLE; only the strobes are qualified.
- All outputs are registered or decoded from state only; there is no combinational path from start to any memory strobe.

Test Plan:
- Reset mid-op: sb started, rst pulsed during MERGE -> no mem_wr_en at any cycle, busy=0 during reset, no done pulse afterwards.
- sw aligned: addr=0x0000_0010, wdata=0xDEADBEEF -> one cycle later mem_wr_en=1, mem_addr=0x4, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never high.
- sb lane 2: addr=0x0000_0022, wdata=0x0000_00A5, mem_rdata=0x11223344 -> mem_rd_en at +1 (mem_addr=0x8); at +3 mem_wdata=0x11A53344, mem_wr_en=1, done=1.
- sh upper half: addr=0x0000_0006, wdata=0xFFFF_BEEF, mem_rdata=0x11223344 -> mem_wdata=0xBEEF3344 at +3. Lower half at addr=0x4 -> 0x1122BEEF.
- Misaligned: sw at 0x13, sh at 0x05, option 2'b10 -> each gives done=1 and misalign=1 at +1, with no memory strobes.
- Busy handling: start pulsed every cycle during an sb -> only the first request executes. A second request asserted the cycle after done completes normally.
